// File: rtl/ir_feed_pkg.sv
// Shared definitions for the instruction-feed queue: FSM encoding and default word width.
package ir_feed_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      GAP   = 2'd2
   } feed_state_t;

   localparam int DEFAULT_WIDTH = 32;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; head word is presented combinationally from storage.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;

   assign head  = mem[rd_ptr];
   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));

   // Storage carries data only, so it is left out of reset.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ir_feed_queue.sv
// Buffers instruction words and issues them to the IR as single-cycle enable pulses
// separated by a programmable, stall-aware idle gap.
module ir_feed_queue
   import ir_feed_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = 8,
   parameter int GAP_W = 4
) (
   input  logic                     Clk,
   input  logic                     RESET,
   input  logic                     flush,
   input  logic                     wr_valid,
   input  logic [WIDTH-1:0]         wr_data,
   output logic                     wr_ready,
   input  logic                     run,
   input  logic                     hold,
   input  logic [GAP_W-1:0]         gap,
   output logic [WIDTH-1:0]         IR_In,
   output logic                     IR_Enable,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);
   feed_state_t      state, state_nxt;
   logic [GAP_W-1:0] gap_cnt, gap_cnt_nxt;
   logic [WIDTH-1:0] head;
   logic             go;
   logic             push;
   logic             pop;
   logic             may_issue;

   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (Clk),
      .rst       (RESET),
      .clear     (flush),
      .push      (push),
      .push_data (wr_data),
      .pop       (pop),
      .head      (head),
      .count     (count),
      .empty     (empty),
      .full      (full)
   );

   assign wr_ready = !full;
   assign push     = wr_valid && !full && !flush;
   assign go       = run && !hold && !empty && !flush;

   // may_issue marks cycles where the FSM is free to start the next issue.
   always_comb begin
      state_nxt   = state;
      gap_cnt_nxt = gap_cnt;
      may_issue   = 1'b0;
      pop         = 1'b0;
      case (state)
         IDLE:  may_issue = 1'b1;
         ISSUE: begin
            if (gap == '0) begin
               may_issue = 1'b1;
            end else begin
               gap_cnt_nxt = gap;
               state_nxt   = GAP;
            end
         end
         GAP: begin
            if (!hold) begin
               if (gap_cnt <= GAP_W'(1)) begin
                  gap_cnt_nxt = '0;
                  may_issue   = 1'b1;
               end else begin
                  gap_cnt_nxt = gap_cnt - GAP_W'(1);
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (may_issue) begin
         if (go) begin
            pop       = 1'b1;
            state_nxt = ISSUE;
         end else begin
            state_nxt = IDLE;
         end
      end
      if (flush) begin
         state_nxt   = IDLE;
         gap_cnt_nxt = '0;
      end
   end

   // Output stage: the popped head word and its enable pulse register together.
   always_ff @(posedge Clk or posedge RESET) begin
      if (RESET) begin
         state     <= IDLE;
         gap_cnt   <= '0;
         IR_Enable <= 1'b0;
         IR_In     <= '0;
      end else begin
         state     <= state_nxt;
         gap_cnt   <= gap_cnt_nxt;
         IR_Enable <= pop;
         if (pop) IR_In <= head;
      end
   end

endmodule

// File: doc/ir_feed_queue.md
# ir_feed_queue

Parametrised instruction-feed queue that sits in front of the SPARC datapath's instruction register. It buffers up to DEPTH instruction words and issues them to the IR as single-cycle `IR_Enable` pulses with `IR_In`, separated by a programmable idle gap. It supports a stall input from the control unit and a synchronous flush. It replaces the hand-timed IR loading sequences with a reusable, depth- and gap-configurable source for system-level runs.

## Interface
- `WIDTH`, default 32: instruction word width.
- `DEPTH`, default 8: queue capacity in words; must be a power of two and at least 2.
- `GAP_W`, default 4: width of the gap field.
- `Clk`  in  1: single clock; all state changes on the rising edge.
- `RESET`  in  1: asynchronous, active-high; clears all state.
- `flush`  in  1: synchronous flush; empties the queue and returns the FSM to IDLE.
- `wr_valid`  in  1: push request.
- `wr_data`  in  WIDTH: word to push.
- `wr_ready`  out  1: equals `!full`. A push occurs when `wr_valid && wr_ready && !flush`.
- `run`  in  1: issue enable.
- `hold`  in  1: control-unit stall. Blocks new issues and freezes the gap counter.
- `gap`  in  GAP_W: number of idle cycles after each issue; sampled in the ISSUE cycle.
- `IR_In`  out  WIDTH: registered; holds the last issued word.
- `IR_Enable`  out  1: registered; one-cycle pulse per issued word.
- `count`  out  $clog2(DEPTH)+1: current occupancy.
- `empty`, `full`  out  1: occupancy flags.

## Operation
- Reset values: `IR_In`=0, `IR_Enable`=0, `count`=0, `empty`=1, `full`=0, `wr_ready`=1, FSM in IDLE, gap counter 0, read and write pointers 0.
- The queue is FIFO ordered. Pointers wrap modulo DEPTH. `count` updates by +1 for a push, -1 for a pop, and stays unchanged for a simultaneous push and pop.
- The issue condition `go` is `run && !hold && !empty && !flush`, evaluated on registered state. A word pushed in cycle n is eligible for issue at the earliest in cycle n+1.
- IDLE: on `go`, pop the head word; the next cycle is ISSUE.
- ISSUE: `IR_Enable`=1 and `IR_In`=the popped word, for exactly one cycle. In this cycle `gap` is sampled:
  - If `gap`=0 and `go` is true, pop again; the next cycle is ISSUE (back-to-back issue).
  - If `gap`=0 and `go` is false, go to IDLE.
  - Otherwise, load the gap counter with `gap` and go to GAP.
- GAP: the counter decrements only on cycles with `hold`=0. When the counter reaches 0, the FSM behaves as IDLE in that same cycle.
- Dropping `run` never truncates a pulse that is already issued. It only prevents later issues.
- `flush` behaviour:
  - In the flush cycle: pointers and `count` go to 0, FSM goes to IDLE, gap counter goes to 0.
  - A push in the same cycle is discarded.
  - An `IR_Enable` pulse already registered for that cycle still completes.
  - `IR_In` keeps its value.
- Push while full is ignored (`wr_ready`=0). When full, a simultaneous pop does not make room in that same cycle.
- `RESET` asserted mid-gap or mid-issue forces all reset values immediately. No pulse completes after `RESET` rises.

## Timing
- Latency: with `run`=1 and `hold`=0, the first `IR_Enable` rises 1 cycle after the cycle in which the queue becomes non-empty.
- Issue period: one issue every `gap`+1 cycles when the queue is non-empty and `hold`=0. Each `hold` cycle during GAP adds one cycle.
- `hold` is sampled every cycle and has no effect on a pulse already registered.
- All outputs are registered or decoded from registers; there are no combinational paths from inputs to outputs.

## Structure
- Package `ir_feed_pkg` holds:
  - FSM state encodings: IDLE, ISSUE, GAP.
  - `DEFAULT_WIDTH`=32.
- Sub-module `sync_fifo` (params WIDTH, DEPTH) provides storage, pointers, `count`, `empty` and `full`.
- `ir_feed_queue` contains the FSM, the gap counter and the output registers.

## Test plan
- Reset: hold `RESET` high 2 cycles, then release. Require `IR_Enable`=0, `IR_In`=0, `empty`=1, `count`=0, `wr_ready`=1.
- Ordered issue: push 82002003, 82002006, 84004002, 050000FF (hex) with `gap`=1 and `run`=1. Require 4 pulses exactly 2 cycles apart, in that order, with `IR_In`=050000FF held after the last pulse.
- Back-to-back and full: with `run`=0, fill DEPTH=8 words. Require `full`=1 and `wr_ready`=0, and a 9th push ignored. Then set `run`=1 with `gap`=0. Require 8 consecutive `IR_Enable` cycles, then `empty`=1.
- Hold: `gap`=3, assert `hold` for 2 cycles during GAP. Require the spacing between pulses to grow from 4 to 6 cycles.
- Flush: with 5 words queued, assert `flush` together with `wr_valid`. Require `count`=0, no further pulses, and the pushed word discarded.
- Reset mid-operation: assert `RESET` during GAP with 3 words queued. Require immediate return to reset values, and no pulse after `RESET` is released until new pushes arrive.
